// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file: default widths,
// LC-3 condition-code bit positions, the reset condition code and the
// NZP helper used at writeback.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  // Bit positions inside the 3-bit {N,Z,P} condition-code vector.
  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  // After reset the machine behaves as if a zero had been written.
  localparam logic [2:0] CC_RESET = 3'b010;

  // Builds {N,Z,P} from the sign bit and a zero flag of the written value.
  // Taking these two bits keeps the helper independent of DATA_W.
  function automatic logic [2:0] nzp(input logic neg, input logic zero);
    logic [2:0] r;
    r       = '0;
    r[CC_N] = neg;
    r[CC_Z] = zero;
    r[CC_P] = !neg && !zero;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for regfile_sb: one busy bit per register.
// Decode reserves the destination, writeback clears it; a reservation wins
// over a same-cycle clear because it represents a newly issued producer.
// busy_next is exported so read ports can observe this cycle's updates.
module regfile_scoreboard #(
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  output logic [(2**ADDR_W)-1:0]   busy_next,
  output logic                     rsv_err,
  output logic                     any_busy
);

  logic [(2**ADDR_W)-1:0] busy;

  // Next busy vector: clear on writeback, then let a reservation override it.
  always_comb begin
    busy_next = busy;
    if (wen)    busy_next[waddr]    = 1'b0;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
  end

  // Busy state plus a one-cycle error pulse when an already pending
  // register is reserved again without being retired in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      rsv_err <= 1'b0;
    end else begin
      busy    <= busy_next;
      rsv_err <= rsv_en && busy[rsv_addr] && !(wen && (waddr == rsv_addr));
    end
  end

  // Summary of the current (not next) state.
  assign any_busy = |busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a pending-write scoreboard
// and LC-3 NZP condition codes for the pipelined LC-3 datapath.
// Optional build macro REGFILE_BYPASS_EN: when defined, a read that hits the
// register being written in the same cycle returns the new data
// (write-first); otherwise it returns the old contents (read-first).
// Interface: no valid/ready handshake; ren, wen and rsv_en are single-cycle
// strobes acted on at every rising edge, and every request is always accepted.
import regfile_pkg::*;

module regfile_sb #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREAD-1:0]          ren,
  input  logic [NREAD*ADDR_W-1:0]   raddr,
  output logic [NREAD*DATA_W-1:0]   rdata,
  output logic [NREAD-1:0]          rbusy,
  input  logic                      wen,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      wcc,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_err,
  output logic                      any_busy,
  output logic [2:0]                cc
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W-1:0] rd_addr [NREAD];
  logic [DATA_W-1:0] rd_val  [NREAD];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wen       (wen),
    .waddr     (waddr),
    .busy_next (busy_next),
    .rsv_err   (rsv_err),
    .any_busy  (any_busy)
  );

  // Register array: cleared on reset, written at writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Per-port read value, with optional same-cycle write forwarding.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd_addr[i] = raddr[i*ADDR_W +: ADDR_W];
      rd_val[i]  = mem[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      if (wen && (rd_addr[i] == waddr)) rd_val[i] = wdata;
`endif
    end
  end

  // Registered read ports; a disabled port holds its last data and busy flag.
  // The busy flag reflects this cycle's reserve/clear via busy_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      rbusy <= '0;
    end else begin
      for (int i = 0; i < NREAD; i++) begin
        if (ren[i]) begin
          rdata[i*DATA_W +: DATA_W] <= rd_val[i];
          rbusy[i]                  <= busy_next[rd_addr[i]];
        end
      end
    end
  end

  // Condition codes follow the value written when wcc is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (wen && wcc) begin
      cc <= nzp(wdata[DATA_W-1], wdata == '0);
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file with a pending-write scoreboard and LC-3 condition-code (NZP) generation.
- Serves the pipelined LC-3 datapath:
  - decode reads operands and reserves the destination register;
  - writeback writes data, clears the reservation and optionally updates NZP.
- Registered reads with optional write-to-read bypass.

Parameters:
- DATA_W, 16, register width in bits (≥2)
- ADDR_W, 3, register address width; depth = 2**ADDR_W
- NREAD, 2, number of independent read ports (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ren  in  NREAD  per-port read enable
- raddr  in  NREAD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W]
- rbusy  out  NREAD  registered busy flag of the register read on port i
- wen  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- wcc  in  1  update condition codes from wdata on this write (ignored unless wen)
- rsv_en  in  1  reserve (mark busy) destination register
- rsv_addr  in  ADDR_W  register to reserve
- rsv_err  out  1  one-cycle pulse: reserved a register already busy and not cleared this cycle
- any_busy  out  1  OR of all busy bits (registered state)
- cc  out  3  {N,Z,P} condition codes

Behaviour:
- Reset (rst_n low, async, immediate):
  - all registers = 0, all busy bits = 0
  - rdata = 0, rbusy = 0, rsv_err = 0
  - cc = 3'b010 (Z)
- Reset deasserted mid-operation: first edge after release behaves normally. No operation issued during reset takes effect.
- Read:
  - 1-cycle latency; at an edge with ren[i]=1, rdata[i] and rbusy[i] load.
  - With ren[i]=0, rdata[i] and rbusy[i] hold their previous values.
  - Ports are independent; identical addresses on several ports are legal.
- Write: wen=1 → data[waddr] <= wdata at the edge.
- Condition codes: wen && wcc → cc <= {N,Z,P}:
  - N = wdata[DATA_W-1]
  - Z = (wdata==0)
  - P = !N && !Z
  - Exactly one bit is set at all times after reset.
- Scoreboard, next-state per register r:
  - rsv_en && rsv_addr==r → busy_next = 1.
  - Otherwise, wen && waddr==r → busy_next = 0.
  - Otherwise busy holds.
  - Reservation wins over a same-cycle clear of the same register (a new producer is issued).
- rbusy[i] <= busy_next[raddr[i]]: the read sees this cycle's reserve/clear.
- rsv_err <= rsv_en && busy[rsv_addr] && !(wen && waddr==rsv_addr). The busy bit stays set. No other effect.
- any_busy is the OR of the current busy bits (state, not next). It is updated one cycle after a reserve/clear.
- Writing a register that is not busy is legal and leaves busy at 0.
- No address wrap issues: all addresses are full-range, and depth is an exact power of two.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: read port i with ren[i] && wen && raddr[i]==waddr loads wdata into rdata[i] (write-first).
- Undefined: rdata[i] loads the pre-write array contents (read-first). The new value is visible from the next read.
- Scoreboard and cc behaviour are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/ADDR_W
  - CC_N/CC_Z/CC_P bit indices
  - CC_RESET constant (3'b010)
  - nzp function (data → 3-bit cc)
- Sub-module regfile_scoreboard (busy vector, busy_next, rsv_err, any_busy), parametrised by ADDR_W.
- Data array, read ports and bypass stay in the top module.

Test Plan:
- Reset check: assert rst_n=0 mid-run after writes → rdata=0, rbusy=0, cc=3'b010, any_busy=0 immediately; read R5 after release → 0.
- Basic write/read: write R3=16'h1234 (wcc=1), next cycle ren[0]=1 raddr0=3 → rdata0=16'h1234 one edge later; cc=3'b001. Write 16'h8000 → cc=3'b100; write 0 → cc=3'b010.
- Dual-port same cycle: R1=16'hAAAA, R2=16'h5555; ren=2'b11, raddr0=1, raddr1=2 → rdata0=16'hAAAA, rdata1=16'h5555. With ren=2'b00 next cycle, both outputs hold.
- Bypass: R4=16'h0001; same edge wen waddr=4 wdata=16'hBEEF and ren0 raddr0=4 → rdata0=16'hBEEF with REGFILE_BYPASS_EN, 16'h0001 without.
- Scoreboard: reserve R6 → any_busy=1 next cycle. Read R6 → rbusy0=1. Write R6 → busy clears, rbusy=0 on the next read. Same-cycle reserve+write R6 → stays busy, rsv_err=0.
- Conflict: reserve R2 twice without a write → second cycle's rsv_err=1 for exactly one cycle, R2 still busy. Reserve R7 while writing R7 after the first reserve → rsv_err=0.
